// File: rtl/bcd_pkg.sv
// bcd_pkg: digit width, digit limit and FSM state encodings shared by the
// BCD conversion paths.
package bcd_pkg;
    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction
endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if: request/result bundle between a BCD digit source and
// the sequential BCD-to-binary converter.
interface bcd_to_binary_seq_if #(parameter int BIN_W = 10);
    logic             start;
    logic [3:0]       Hundreds;
    logic [3:0]       Tens;
    logic [3:0]       Ones;
    logic [BIN_W-1:0] binary;
    logic             busy;
    logic             done;
    logic             err;
    modport master (output start, Hundreds, Tens, Ones, input binary, busy, done, err);
    modport slave  (input start, Hundreds, Tens, Ones, output binary, busy, done, err);
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: halving correction for one BCD digit after a right shift;
// a borrowed 8 really stands for 5, so subtract 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    assign q = (d >= BCD_DIGIT_W'(8)) ? d - BCD_DIGIT_W'(3) : d;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: converts three BCD digits to binary with reverse
// double-dabble, one result bit per clock.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input logic clk,
    input logic rst_n,
    bcd_to_binary_seq_if.slave bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj, bcd_in;
    logic [BIN_W-1:0]   bin_q, bin_d, binary_q, binary_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d, bad_q, bad_d;
    logic [BCD_W+BIN_W-1:0] sh;
    logic               in_bad;

    assign bcd_in = BCD_W'({bus.Hundreds, bus.Tens, bus.Ones});
    assign in_bad = digit_bad(bus.Hundreds) | digit_bad(bus.Tens) | digit_bad(bus.Ones);
    assign sh     = {bcd_q, bin_q} >> 1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(sh[BIN_W + i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q(bcd_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        binary_d = binary_q;
        err_d    = err_q;
        bad_d    = bad_q;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                bcd_d   = bcd_in;
                bin_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                bad_d   = in_bad;
                state_d = in_bad ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                bcd_d = bcd_adj;
                bin_d = sh[BIN_W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end
            end
            ST_DONE: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                binary_d = bad_q ? '0 : bin_q;
                err_d    = bad_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            binary_q <= '0;
            err_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            binary_q <= binary_d;
            err_q    <= err_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.binary = binary_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed and randomized conversions checked against
// decimal arithmetic on the entered digits.
module tb_bcd_to_binary_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bcd_to_binary_seq_if #(.BIN_W(10)) bus ();
    bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                        input bit hold, input int poke);
        logic        exp_e;
        logic [31:0] exp_b;
        logic [9:0]  prev;
        int          lat;
        int          bc;
        exp_e = (h > 9) || (t > 9) || (o > 9);
        exp_b = exp_e ? 0 : 100 * h + 10 * t + o;
        prev  = bus.binary;
        bus.Hundreds = h;
        bus.Tens     = t;
        bus.Ones     = o;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        chk("accept_busy", bus.busy, 1);
        lat = 0;
        bc  = 0;
        if (bus.busy) bc++;
        while (!bus.done && lat < 40) begin
            if (poke != 0 && lat == poke) begin
                bus.Hundreds = 1; bus.Tens = 1; bus.Ones = 1; bus.start = 1'b1;
            end else if (poke != 0 && lat == poke + 1) bus.start = 1'b0;
            chk("hold_binary", bus.binary, prev);
            @(posedge clk); #1;
            lat++;
            if (bus.busy) bc++;
        end
        chk("latency", lat, exp_e ? 1 : 11);
        chk("busy_cycles", bc, exp_e ? 1 : 10);
        chk("binary", bus.binary, exp_b);
        chk("err", bus.err, exp_e);
    endtask

    initial begin
        int extra;
        bus.start = 1'b0;
        bus.Hundreds = 0; bus.Tens = 0; bus.Ones = 0;
        #12;
        chk("rst_binary", bus.binary, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        conv(0, 0, 0, 0, 0);
        conv(9, 9, 9, 0, 0);
        conv(4, 2, 7, 1, 0);
        conv(1, 0, 5, 0, 0);
        conv(0, 4'hA, 3, 0, 0);
        conv(3, 0, 0, 0, 0);
        conv(5, 5, 5, 0, 3);
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done) extra++;
        end
        chk("single_done", extra, 0);

        bus.Hundreds = 8; bus.Tens = 6; bus.Ones = 4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_binary", bus.binary, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_err", bus.err, 0);
        #3 rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done) extra++;
        end
        chk("abort_no_done", extra, 0);
        conv(0, 1, 2, 0, 0);

        for (int n = 0; n < 1000; n++)
            conv(4'(n / 100), 4'((n / 10) % 10), 4'(n % 10), 0, 0);
        for (int k = 0; k < 150; k++)
            conv(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
